// File: rtl/shift_sub_divider.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sub_divider
//  Brief    : Sequential restoring unsigned divider (shift / conditional subtract)
//             with St/Idle/Done handshake and divide-by-zero flag.
//  Revision : 1.0
// ============================================================================
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             St,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Idle,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             idle_q, idle_d;
    logic             done_q, done_d;

    logic             w_ge;
    logic [WIDTH:0]   w_a_upd;
    logic [WIDTH-1:0] w_q_upd;

    // Restoring step: subtract only when the partial remainder covers B.
    assign w_ge    = (a_q >= {1'b0, b_q});
    assign w_a_upd = w_ge ? (a_q - {1'b0, b_q}) : a_q;
    assign w_q_upd = {q_q[WIDTH-1:1], w_ge};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (St) begin
                    if (Divisor != '0) begin
                        a_d     = '0;
                        q_d     = Dividend;
                        b_d     = Divisor;
                        cnt_d   = C_CNT_LAST;
                        state_d = S_SHIFT;
                    end else begin
                        quo_d   = '1;
                        rem_d   = Dividend;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                a_d     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d     = {q_q[WIDTH-2:0], 1'b0};
                state_d = S_SUB;
            end
            S_SUB: begin
                a_d = w_a_upd;
                q_d = w_q_upd;
                if (cnt_q == '0) begin
                    quo_d   = w_q_upd;
                    rem_d   = w_a_upd[WIDTH-1:0];
                    dz_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moore flags registered from the next state so they track state_q exactly.
        idle_d = (state_d == S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
        end
    end

    assign Idle      = idle_q;
    assign Done      = done_q;
    assign DivZero   = dz_q;
    assign Quotient  = quo_q;
    assign Remainder = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
`default_nettype none
// Self-checking bench for shift_sub_divider (WIDTH = 8) against a plain-arithmetic reference.
module tb_shift_sub_divider;

    localparam int W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         St;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Idle;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;

    int vectors;
    int miscompares;

    shift_sub_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .St        (St),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Idle      (Idle),
        .Done      (Done),
        .DivZero   (DivZero),
        .Quotient  (Quotient),
        .Remainder (Remainder)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Starts one operation from IDLE, scrambles operands after acceptance and
    // counts rising edges from acceptance until Done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat, output logic stable);
        logic [W-1:0] q0, r0;
        q0     = Quotient;
        r0     = Remainder;
        stable = 1'b1;
        St       = 1'b1;
        Dividend = a;
        Divisor  = b;
        @(posedge Clk); #1;
        St       = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
        lat = 0;
        while (!Done && lat < 100) begin
            if (Quotient !== q0 || Remainder !== r0) stable = 1'b0;
            @(posedge Clk); #1;
            lat++;
        end
        q  = Quotient;
        r  = Remainder;
        dz = DivZero;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; St = 1'b0; Dividend = '0; Divisor = '0;
        @(posedge Clk); #1;
        vectors++;
        if ({Idle, Done, DivZero, Quotient, Remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got idle=%b done=%b dz=%b q=%0d r=%0d, want idle=1 done=0 dz=0 q=0 r=0",
                     Idle, Done, DivZero, Quotient, Remainder);
        end
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        vectors++;
        if (Idle !== 1'b1 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got idle=%b done=%b, want idle=1 done=0", Idle, Done);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] q, r; logic dz, st; int lat;
        run_op(8'd100, 8'd7, q, r, dz, lat, st);
        vectors++;
        if (lat !== 2 * W) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d edges, want %0d", lat, 2 * W);
        end
        vectors++;
        if (q !== 8'd14 || r !== 8'd2 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want q=14 r=2 dz=0", q, r, dz);
        end
        vectors++;
        if (Idle !== 1'b1 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after_done: got idle=%b done=%b, want idle=1 done=0", Idle, Done);
        end
    endtask

    task automatic test_edges;
        logic [W-1:0] av[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
        logic [W-1:0] bv[4] = '{8'd1,   8'd9, 8'd3, 8'd255};
        logic [W-1:0] eq[4] = '{8'd255, 8'd0, 8'd0, 8'd1};
        logic [W-1:0] er[4] = '{8'd0,   8'd5, 8'd0, 8'd0};
        logic [W-1:0] q, r; logic dz, st; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], q, r, dz, lat, st);
            vectors++;
            if (q !== eq[i] || r !== er[i] || dz !== 1'b0 || lat !== 2 * W) begin
                miscompares++;
                $display("FAIL edge_%0d/%0d: got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=0 lat=%0d",
                         av[i], bv[i], q, r, dz, lat, eq[i], er[i], 2 * W);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [W-1:0] q, r; logic dz, st; int lat;
        run_op(8'd200, 8'd0, q, r, dz, lat, st);
        vectors++;
        if (lat !== 0) begin
            miscompares++;
            $display("FAIL divzero_latency: got %0d edges, want 0", lat);
        end
        vectors++;
        if (q !== 8'd255 || r !== 8'd200 || dz !== 1'b1) begin
            miscompares++;
            $display("FAIL divzero_result: got q=%0d r=%0d dz=%b, want q=255 r=200 dz=1", q, r, dz);
        end
        vectors++;
        if (DivZero !== 1'b1 || Quotient !== 8'd255) begin
            miscompares++;
            $display("FAIL divzero_hold: got dz=%b q=%0d in idle, want dz=1 q=255", DivZero, Quotient);
        end
        run_op(8'd9, 8'd3, q, r, dz, lat, st);
        vectors++;
        if (q !== 8'd3 || r !== 8'd0 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL divzero_followup: got q=%0d r=%0d dz=%b, want q=3 r=0 dz=0", q, r, dz);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] q, r; logic dz, st, saw_done; int lat;
        run_op(8'd77, 8'd4, q, r, dz, lat, st);
        vectors++;
        if (q !== 8'd19 || r !== 8'd1) begin
            miscompares++;
            $display("FAIL pre_reset_op: got q=%0d r=%0d, want q=19 r=1", q, r);
        end
        St = 1'b1; Dividend = 8'd200; Divisor = 8'd3;
        @(posedge Clk); #1;
        St = 1'b0;
        repeat (5) begin @(posedge Clk); #1; end
        Rst_n = 1'b0;
        #1;
        vectors++;
        if ({Idle, Done, DivZero, Quotient, Remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL midop_reset: got idle=%b done=%b dz=%b q=%0d r=%0d, want idle=1 done=0 dz=0 q=0 r=0",
                     Idle, Done, DivZero, Quotient, Remainder);
        end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (Done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_no_done: got a Done pulse after abort, want none");
        end
        run_op(8'd50, 8'd6, q, r, dz, lat, st);
        vectors++;
        if (q !== 8'd8 || r !== 8'd2 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_op: got q=%0d r=%0d dz=%b, want q=8 r=2 dz=0", q, r, dz);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_a[$];
        logic [W-1:0] exp_b[$];
        logic [W-1:0] ea, eb;
        int cyc, last_done, n_done, guard;
        St = 1'b1;
        Dividend = 8'd123; Divisor = 8'd10;
        last_done = -1; n_done = 0;
        for (cyc = 0; cyc < 80; cyc++) begin
            if (Done) begin
                if (exp_a.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b2b_spurious_done: got Done at cycle %0d, want none", cyc);
                end else begin
                    ea = exp_a.pop_front(); eb = exp_b.pop_front();
                    vectors++;
                    if (Quotient !== ea / eb || Remainder !== ea % eb) begin
                        miscompares++;
                        $display("FAIL b2b_result %0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                                 ea, eb, Quotient, Remainder, ea / eb, ea % eb);
                    end
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (cyc - last_done !== 2 * W + 2) begin
                        miscompares++;
                        $display("FAIL b2b_spacing: got %0d cycles, want %0d", cyc - last_done, 2 * W + 2);
                    end
                end
                last_done = cyc;
                n_done++;
            end
            if (Idle) begin
                exp_a.push_back(Dividend);
                exp_b.push_back(Divisor);
            end else begin
                Dividend = W'($urandom);
                Divisor  = W'($urandom_range(1, 255));
            end
            @(posedge Clk); #1;
        end
        St = 1'b0;
        guard = 0;
        while (exp_a.size() != 0 && guard < 100) begin
            if (Done) begin
                ea = exp_a.pop_front(); eb = exp_b.pop_front();
                vectors++;
                if (Quotient !== ea / eb || Remainder !== ea % eb) begin
                    miscompares++;
                    $display("FAIL b2b_tail %0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                             ea, eb, Quotient, Remainder, ea / eb, ea % eb);
                end
            end
            @(posedge Clk); #1;
            guard++;
        end
        vectors++;
        if (exp_a.size() != 0 || n_done < 3) begin
            miscompares++;
            $display("FAIL b2b_drain: got %0d pending, %0d dones, want 0 pending and >=3 dones",
                     exp_a.size(), n_done);
        end
        while (!Idle && guard < 200) begin @(posedge Clk); #1; guard++; end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, q, r; logic dz, st; int lat;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom_range(1, 255));
            run_op(a, b, q, r, dz, lat, st);
            vectors++;
            if (q !== a / b || r !== a % b || dz !== 1'b0 || lat !== 2 * W) begin
                miscompares++;
                $display("FAIL rand %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=0 lat=%0d",
                         a, b, q, r, dz, lat, a / b, a % b, 2 * W);
            end
            vectors++;
            if (!((32'(q) * 32'(b) + 32'(r) == 32'(a)) && (r < b))) begin
                miscompares++;
                $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d, want q*b+r==a and r<b", a, b, q, r);
            end
            vectors++;
            if (st !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_stable %0d/%0d: got results changing before Done, want stable", a, b);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
Sequential restoring divider for unsigned operands, using shift and conditional subtract. It is the inverse companion of the shift-add multiplier and shares its handshake style: St starts an operation, Idle marks readiness, Done pulses when the result is valid. It contains the control FSM, the working registers (A, Q, B), the iteration counter and the result registers. It sits beside the multiplier in the CPU execution datapath.

Parameters:
WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder (minimum 2).

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Rst_n  input  1  asynchronous active-low reset.
St  input  1  start request; sampled only in IDLE.
Dividend  input  WIDTH  unsigned dividend; sampled on the edge that accepts St.
Divisor  input  WIDTH  unsigned divisor; sampled on the edge that accepts St.
Idle  output  1  high while the FSM is in IDLE.
Done  output  1  high for exactly one cycle, in DONE.
DivZero  output  1  registered; set when the last accepted operation had Divisor == 0.
Quotient  output  WIDTH  registered result; held until the next result is captured.
Remainder  output  WIDTH  registered result; held until the next result is captured.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - state = IDLE.
  - A, Q, B, counter, Quotient, Remainder and DivZero all cleared to 0.
  - Idle = 1, Done = 0.
  - Reset mid-operation aborts the operation, and no Done pulse is produced.
- Idle and Done are Moore outputs, decoded from the state only.
- Working registers: A is WIDTH+1 bits (partial remainder), Q is WIDTH bits, B is WIDTH bits, counter is ceil(log2(WIDTH)) bits.
- IDLE:
  - St = 0: stay in IDLE.
  - St = 1 and Divisor != 0: A <= 0, Q <= Dividend, B <= Divisor, counter <= WIDTH-1, go to SHIFT.
  - St = 1 and Divisor == 0: Quotient <= all ones, Remainder <= Dividend, DivZero <= 1, go to DONE.
- SHIFT: {A,Q} <= {A,Q} << 1, with Q[0] <= 0; go to SUB.
- SUB:
  - If A >= {1'b0,B}: A <= A - B and Q[0] <= 1; otherwise A and Q are unchanged (restoring).
  - K = (counter == 0).
  - K = 0: counter <= counter - 1, go to SHIFT.
  - K = 1: Quotient <= updated Q, Remainder <= updated A[WIDTH-1:0], DivZero <= 0, go to DONE.
- DONE: Done = 1; go to IDLE unconditionally.
- Latency:
  - Normal operation: Done is high in the cycle after the (2*WIDTH)-th rising edge following the St-accepting edge (edge 16 for WIDTH = 8).
  - Divide by zero: Done is high in the cycle immediately after the accepting edge.
- St outside IDLE is ignored and is not queued; the next start needs St high while Idle = 1.
- Back-to-back operation: St held high continuously starts a new operation on every IDLE visit, so the minimum period is 2*WIDTH+2 cycles.
- Dividend and Divisor may change freely after the accepting edge without affecting the operation in flight.
- Quotient, Remainder and DivZero change only on the edge entering DONE, so they stay stable through IDLE and the next operation.
- Arithmetic invariant for Divisor != 0: Quotient*Divisor + Remainder == Dividend, and Remainder < Divisor.

Test Plan:
- WIDTH=8; Dividend=100, Divisor=7, St pulsed for 1 cycle -> Done high exactly 16 edges after acceptance; Quotient=14, Remainder=2, DivZero=0; Idle=1 on the following cycle.
- Edge operands: 255/1 -> Q=255, R=0; 5/9 -> Q=0, R=5; 0/3 -> Q=0, R=0; 255/255 -> Q=1, R=0.
- Divide by zero: 200/0 -> Done on the cycle after acceptance; Q=255, R=200, DivZero=1. A following 9/3 -> Q=3, R=0, DivZero=0.
- Rst_n pulsed low at cycle 6 of an operation -> outputs cleared immediately, Idle=1, no Done pulse. A new 50/6 then gives Q=8, R=2.
- St held high throughout and operand changes mid-operation -> no restart while busy, results match the operands sampled at acceptance, consecutive Done pulses spaced 18 cycles apart.
- Randomised: 1000 random 8-bit pairs with Divisor != 0 -> checked against the arithmetic invariant, and Quotient/Remainder stable between Done pulses.
